// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush sequencer (slave).
// It carries the ID/EX hazard sources, the MUL/DIV and data-memory status, and all stall/flush/counter outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             md_start;
  logic             md_done;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             exmem_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_bubble;
  logic             memwb_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout_err;

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    input  ex_mem_read, ex_rd, ex_redirect, md_start, md_done,
    input  mem_req, mem_ready,
    output pc_stall, ifid_stall, idex_stall, exmem_stall,
    output ifid_flush, idex_flush, exmem_bubble, memwb_bubble,
    output md_busy, stall_cycles, flush_count, mem_timeout_err
  );

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
    output ex_mem_read, ex_rd, ex_redirect, md_start, md_done,
    output mem_req, mem_ready,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall,
    input  ifid_flush, idex_flush, exmem_bubble, memwb_bubble,
    input  md_busy, stall_cycles, flush_count, mem_timeout_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, redirects, memory waits, MUL/DIV.
// Also keeps stall/flush performance counters and a sticky memory-wait watchdog flag.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done_pending;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             r_mem_timeout_err;

  logic w_mem_wait;
  logic w_load_use;
  logic w_md_fin;
  logic w_md_hold;
  logic w_redirect_fire;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_idex_stall;
  logic w_exmem_stall;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_exmem_bubble;
  logic w_memwb_bubble;
  logic w_timeout_hit;

  assign w_mem_wait = hz.mem_req & ~hz.mem_ready;
  assign w_load_use = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                      ((hz.id_uses_rs1 & (hz.ex_rd == hz.id_rs1_addr)) |
                       (hz.id_uses_rs2 & (hz.ex_rd == hz.id_rs2_addr)));
  assign w_md_fin   = hz.md_done | r_done_pending;
  assign w_md_hold  = ((r_state == RUN) & hz.md_start) |
                      ((r_state == MD_BUSY) & ~w_md_fin);

  // Watchdog fires on the wait cycle that brings the consecutive count up to the limit.
  assign w_timeout_hit = w_mem_wait &&
                         (({1'b0, r_wait_cnt} + 9'd1) >= 9'(MEM_TIMEOUT));

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_stall      = 1'b0;
    w_ifid_stall    = 1'b0;
    w_idex_stall    = 1'b0;
    w_exmem_stall   = 1'b0;
    w_ifid_flush    = 1'b0;
    w_idex_flush    = 1'b0;
    w_exmem_bubble  = 1'b0;
    w_memwb_bubble  = 1'b0;
    w_redirect_fire = 1'b0;

    if (rst) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_mem_wait) begin
      w_pc_stall     = 1'b1;
      w_ifid_stall   = 1'b1;
      w_idex_stall   = 1'b1;
      w_exmem_stall  = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (w_md_hold) begin
      w_pc_stall     = 1'b1;
      w_ifid_stall   = 1'b1;
      w_idex_stall   = 1'b1;
      w_exmem_bubble = 1'b1;
    end else if (hz.ex_redirect) begin
      w_ifid_flush    = 1'b1;
      w_idex_flush    = 1'b1;
      w_redirect_fire = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall   = 1'b1;
      w_ifid_stall = 1'b1;
      w_idex_flush = 1'b1;
    end

    // A frozen EX stage re-presents md_start, so launches wait out any memory stall.
    case (r_state)
      RUN:     if (hz.md_start & ~w_mem_wait) w_state_nxt = MD_BUSY;
      MD_BUSY: if (w_md_fin & ~w_mem_wait)    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= RUN;
      r_done_pending    <= 1'b0;
      r_wait_cnt        <= 8'd0;
      r_stall_cycles    <= '0;
      r_flush_count     <= '0;
      r_mem_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == MD_BUSY) && (w_state_nxt == RUN))
        r_done_pending <= 1'b0;
      else if ((r_state == MD_BUSY) && hz.md_done && w_mem_wait)
        r_done_pending <= 1'b1;
      if (w_mem_wait)
        r_wait_cnt <= (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
      else
        r_wait_cnt <= 8'd0;
      if (w_pc_stall)      r_stall_cycles    <= r_stall_cycles + CNT_W'(1);
      if (w_redirect_fire) r_flush_count     <= r_flush_count + CNT_W'(1);
      if (w_timeout_hit)   r_mem_timeout_err <= 1'b1;
    end
  end

  assign hz.pc_stall        = w_pc_stall;
  assign hz.ifid_stall      = w_ifid_stall;
  assign hz.idex_stall      = w_idex_stall;
  assign hz.exmem_stall     = w_exmem_stall;
  assign hz.ifid_flush      = w_ifid_flush;
  assign hz.idex_flush      = w_idex_flush;
  assign hz.exmem_bubble    = w_exmem_bubble;
  assign hz.memwb_bubble    = w_memwb_bubble;
  assign hz.md_busy         = (r_state == MD_BUSY) & ~rst;
  assign hz.stall_cycles    = r_stall_cycles;
  assign hz.flush_count     = r_flush_count;
  assign hz.mem_timeout_err = r_mem_timeout_err;

endmodule
